// File: rtl/store_monitor_pkg.sv
// Shared types for the store-port monitor: FSM states, failure codes, log entry layout.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    RUN,
    PASS,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_BAD_VALUE,
    FC_MISALIGNED,
    FC_TIMEOUT
  } fail_code_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

  localparam int LOG_ENTRY_W = $bits(log_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: head visible combinationally from registered storage, zero when empty.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot, so a push while full still lands when paired with a pop.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_port_monitor.sv
// Responder on the core's store port: decides pass/fail from a tohost store, runs a watchdog,
// and logs accepted stores into a drop-on-full FIFO. Status is registered, one edge after the store.
module store_port_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = 32'd100,
  parameter logic [31:0] PASS_VALUE     = 32'd25,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          LOG_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] cycle_count,
  output logic [15:0] store_count,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  state_t     state;
  state_t     next_state;
  fail_code_t fc_q;
  fail_code_t next_fc;
  log_entry_t push_entry;
  log_entry_t head_entry;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop_taken;

  assign accept    = MemWrite && (state == RUN);
  assign pop_taken = log_ready && !fifo_empty;

  // Misalignment outranks the tohost check, and any deciding store outranks the watchdog.
  always_comb begin
    next_state = state;
    next_fc    = fc_q;
    if (state == RUN) begin
      if (accept && (DataAdr[1:0] != 2'b00)) begin
        next_state = FAIL;
        next_fc    = FC_MISALIGNED;
      end else if (accept && (DataAdr == TOHOST_ADDR)) begin
        if (WriteData == PASS_VALUE) begin
          next_state = PASS;
        end else begin
          next_state = FAIL;
          next_fc    = FC_BAD_VALUE;
        end
      end else if (cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
        next_state = FAIL;
        next_fc    = FC_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      fc_q         <= FC_NONE;
      cycle_count  <= '0;
      store_count  <= '0;
      log_overflow <= 1'b0;
    end else begin
      state <= next_state;
      fc_q  <= next_fc;
      if ((state == RUN) && (next_state == RUN)) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (accept && (store_count != 16'hFFFF)) begin
        store_count <= store_count + 16'd1;
      end
      if (accept && fifo_full && !pop_taken) begin
        log_overflow <= 1'b1;
      end
    end
  end

  assign done      = (state != RUN);
  assign pass      = (state == PASS);
  assign fail_code = fc_q;

  assign push_entry.addr = DataAdr;
  assign push_entry.data = WriteData;

  sync_fifo #(
    .WIDTH (LOG_ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (log_ready),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign log_valid = !fifo_empty;
  assign log_addr  = head_entry.addr;
  assign log_data  = head_entry.data;

endmodule

// File: tb/tb_store_port_monitor.sv
// Vector table plus log scoreboard for store_port_monitor, with hand sequences for watchdog corners.
module tb_store_port_monitor;
  import store_monitor_pkg::*;

  localparam logic [31:0] SKIP = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        log_ready = 1'b0;

  logic        done, pass, log_valid, log_overflow;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count, log_addr, log_data;
  logic [15:0] store_count;

  logic        t_done, t_pass, t_log_valid, t_log_overflow;
  logic [1:0]  t_fail_code;
  logic [31:0] t_cycle_count, t_log_addr, t_log_data;
  logic [15:0] t_store_count;

  logic        m_done, m_pass, m_log_valid, m_log_overflow;
  logic [1:0]  m_fail_code;
  logic [31:0] m_cycle_count, m_log_addr, m_log_data;
  logic [15:0] m_store_count;

  always #5 clk = ~clk;

  store_port_monitor dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(done), .pass(pass), .fail_code(fail_code), .cycle_count(cycle_count),
    .store_count(store_count), .log_valid(log_valid), .log_ready(log_ready),
    .log_addr(log_addr), .log_data(log_data), .log_overflow(log_overflow)
  );

  store_port_monitor #(.TIMEOUT_CYCLES(10)) dut_t (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(t_done), .pass(t_pass), .fail_code(t_fail_code), .cycle_count(t_cycle_count),
    .store_count(t_store_count), .log_valid(t_log_valid), .log_ready(log_ready),
    .log_addr(t_log_addr), .log_data(t_log_data), .log_overflow(t_log_overflow)
  );

  store_port_monitor #(.TOHOST_ADDR(32'd102)) dut_m (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(m_done), .pass(m_pass), .fail_code(m_fail_code), .cycle_count(m_cycle_count),
    .store_count(m_store_count), .log_valid(m_log_valid), .log_ready(log_ready),
    .log_addr(m_log_addr), .log_data(m_log_data), .log_overflow(m_log_overflow)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        push;
    logic        done;
    logic        pass;
    logic [1:0]  fc;
    logic [15:0] sc;
    logic        lv;
    logic        ovf;
    logic [31:0] cc;
  } vec_t;

  vec_t       vecs[$];
  log_entry_t sb[$];
  int         total = 0;
  int         bad = 0;

  function automatic vec_t mk(logic rst, logic we, logic [31:0] addr, logic [31:0] data,
                              logic rdy, logic push, logic d, logic p, logic [1:0] fc,
                              logic [15:0] sc, logic lv, logic ovf, logic [31:0] cc);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.data = data; v.rdy = rdy; v.push = push;
    v.done = d; v.pass = p; v.fc = fc; v.sc = sc; v.lv = lv; v.ovf = ovf; v.cc = cc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic we, logic [31:0] addr, logic [31:0] data, logic rdy);
    reset     = !rst;
    MemWrite  = we;
    DataAdr   = addr;
    WriteData = data;
    log_ready = rdy;
    @(negedge clk);
  endtask

  function automatic vec_t rst_row();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'd0, 0, 0, 32'd0);
  endfunction

  initial begin
    log_entry_t exp_e;
    vec_t       v;

    // Basic pass: non-tohost store then the pass store, then drain.
    vecs.push_back(rst_row());
    vecs.push_back(mk(0, 1, 96, 7, 0, 1, 0, 0, 2'd0, 16'd1, 1, 0, 32'd1));
    vecs.push_back(mk(0, 1, 100, 25, 0, 1, 1, 1, 2'd0, 16'd2, 1, 0, SKIP));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 2'd0, 16'd2, 1, 0, SKIP));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 2'd0, 16'd2, 0, 0, SKIP));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 2'd0, 16'd2, 0, 0, SKIP));
    // Bad tohost value, then a later store is ignored.
    vecs.push_back(rst_row());
    vecs.push_back(mk(0, 1, 100, 24, 0, 1, 1, 0, 2'd1, 16'd1, 1, 0, SKIP));
    vecs.push_back(mk(0, 1, 100, 25, 0, 0, 1, 0, 2'd1, 16'd1, 1, 0, SKIP));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 2'd1, 16'd1, 0, 0, SKIP));
    // Misaligned stores, including tohost+2.
    vecs.push_back(rst_row());
    vecs.push_back(mk(0, 1, 98, 5, 0, 1, 1, 0, 2'd2, 16'd1, 1, 0, SKIP));
    vecs.push_back(rst_row());
    vecs.push_back(mk(0, 1, 102, 5, 0, 1, 1, 0, 2'd2, 16'd1, 1, 0, SKIP));
    // Overflow: six stores into four slots, then push+pop while full, drain, empty push+pop.
    vecs.push_back(rst_row());
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0, 1, 32'(4 * k), 32'(32'hA0 + k), 0, (k < 4), 0, 0, 2'd0,
                        16'(k + 1), 1, (k >= 4), 32'(k + 1)));
    vecs.push_back(mk(0, 1, 24, 32'hA6, 1, 1, 0, 0, 2'd0, 16'd7, 1, 1, 32'd7));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 16'd7, 1, 1, 32'd8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 16'd7, 1, 1, 32'd9));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 16'd7, 1, 1, 32'd10));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 16'd7, 0, 1, 32'd11));
    vecs.push_back(mk(0, 1, 28, 32'hA7, 1, 1, 0, 0, 2'd0, 16'd8, 1, 1, 32'd12));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 16'd8, 0, 1, 32'd13));
    // Reset while in PASS with three logged entries; the store in the reset cycle is discarded.
    vecs.push_back(rst_row());
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 2'd0, 16'd1, 1, 0, 32'd1));
    vecs.push_back(mk(0, 1, 4, 2, 0, 1, 0, 0, 2'd0, 16'd2, 1, 0, 32'd2));
    vecs.push_back(mk(0, 1, 100, 25, 0, 1, 1, 1, 2'd0, 16'd3, 1, 0, SKIP));
    vecs.push_back(mk(1, 1, 100, 24, 1, 0, 0, 0, 2'd0, 16'd0, 0, 0, 32'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'd0, 0, 0, 32'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'd0, 0, 0, 32'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) sb.delete();
      if (!v.rst && v.rdy && log_valid) begin
        if (sb.size() == 0) begin
          chk($sformatf("row%0d unexpected_log_entry", i), {31'd0, log_valid}, 32'd0);
        end else begin
          exp_e = sb.pop_front();
          chk($sformatf("row%0d log_addr", i), log_addr, exp_e.addr);
          chk($sformatf("row%0d log_data", i), log_data, exp_e.data);
        end
      end
      if (v.push) sb.push_back('{addr: v.addr, data: v.data});
      drive(v.rst, v.we, v.addr, v.data, v.rdy);
      chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, v.done});
      chk($sformatf("row%0d pass", i), {31'd0, pass}, {31'd0, v.pass});
      chk($sformatf("row%0d fail_code", i), {30'd0, fail_code}, {30'd0, v.fc});
      chk($sformatf("row%0d store_count", i), {16'd0, store_count}, {16'd0, v.sc});
      chk($sformatf("row%0d log_valid", i), {31'd0, log_valid}, {31'd0, v.lv});
      chk($sformatf("row%0d log_overflow", i), {31'd0, log_overflow}, {31'd0, v.ovf});
      if (v.cc != SKIP) chk($sformatf("row%0d cycle_count", i), cycle_count, v.cc);
      if (!v.lv) begin
        chk($sformatf("row%0d empty_log_addr", i), log_addr, 32'd0);
        chk($sformatf("row%0d empty_log_data", i), log_data, 32'd0);
      end
    end

    // Overridden tohost at 102: misalignment still wins over the pass value.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 102, 25, 0);
    chk("mis_override done", {31'd0, m_done}, 32'd1);
    chk("mis_override pass", {31'd0, m_pass}, 32'd0);
    chk("mis_override fail_code", {30'd0, m_fail_code}, 32'd2);
    chk("mis_default fail_code", {30'd0, fail_code}, 32'd2);

    // Watchdog with a 10-cycle budget and no stores.
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) drive(0, 0, 0, 0, 0);
    chk("timeout pre done", {31'd0, t_done}, 32'd0);
    chk("timeout pre cycle_count", t_cycle_count, 32'd9);
    drive(0, 0, 0, 0, 0);
    chk("timeout done", {31'd0, t_done}, 32'd1);
    chk("timeout pass", {31'd0, t_pass}, 32'd0);
    chk("timeout fail_code", {30'd0, t_fail_code}, 32'd3);
    chk("timeout cycle_count", t_cycle_count, 32'd9);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0);
    chk("timeout frozen cycle_count", t_cycle_count, 32'd9);
    chk("timeout sticky done", {31'd0, t_done}, 32'd1);

    // A pass store on the timeout cycle takes priority.
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) drive(0, 0, 0, 0, 0);
    drive(0, 1, 100, 25, 0);
    chk("timeout_vs_pass done", {31'd0, t_done}, 32'd1);
    chk("timeout_vs_pass pass", {31'd0, t_pass}, 32'd1);
    chk("timeout_vs_pass fail_code", {30'd0, t_fail_code}, 32'd0);
    chk("timeout_vs_pass store_count", {16'd0, t_store_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_port_monitor.md
# store_port_monitor

Synthesizable responder on the core's data-store port (`MemWrite`, `DataAdr`, `WriteData`), instantiated beside `top` in simulation and FPGA builds. It accepts every store the core issues, decides pass/fail from a store to a "tohost" address, runs a watchdog, and buffers recent stores in a small log FIFO that the bench or a debug UART drains. It replaces ad hoc `$display` checking with registered status outputs.

## Interface
- `TOHOST_ADDR`, 100: store address that ends the test.
- `PASS_VALUE`, 25: `WriteData` at `TOHOST_ADDR` meaning pass.
- `TIMEOUT_CYCLES`, 1000: RUN cycles before timeout failure; must be ≥1.
- `LOG_DEPTH`, 4: log FIFO entries, power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low: `reset==0` at a rising edge resets all state.
- `MemWrite`  in  1  store strobe, one store per cycle while high.
- `DataAdr`  in  32  store byte address.
- `WriteData`  in  32  store data.
- `done`  out  1  test decided; sticky.
- `pass`  out  1  valid when `done`.
- `fail_code`  out  2  00 none, 01 bad tohost value, 10 misaligned store, 11 timeout.
- `cycle_count`  out  32  RUN cycles elapsed.
- `store_count`  out  16  stores accepted in RUN, saturating at 0xFFFF.
- `log_valid`  out  1  FIFO non-empty.
- `log_ready`  in  1  pop request; pops when `log_valid && log_ready`.
- `log_addr`, `log_data`  out  32 each  head entry; 0 when empty.
- `log_overflow`  out  1  sticky: a push was dropped.

## Operation
- States: RUN (after reset), PASS, FAIL. PASS and FAIL are terminal until reset.
- In RUN with `MemWrite==1`, the store is accepted: pushed to the log, `store_count`++. Classification, in priority order:
  - `DataAdr[1:0]!=0` → FAIL, code 10.
  - `DataAdr==TOHOST_ADDR`, `WriteData==PASS_VALUE` → PASS.
  - `DataAdr==TOHOST_ADDR`, any other value → FAIL, code 01.
  - Otherwise: remain in RUN.
- In RUN, `cycle_count` increments every cycle. If it equals `TIMEOUT_CYCLES-1` and no store decides in that cycle, the next state is FAIL, code 11. A deciding store in the same cycle takes priority over timeout.
- In PASS/FAIL, stores are ignored: no push, no count. `cycle_count` freezes.
- `done = (state!=RUN)`, `pass = (state==PASS)`. `fail_code` is 00 in RUN and PASS.
- Log FIFO: push on accepted store, pop on `log_valid && log_ready`. Pop works in every state.
  - Full + push + pop: both happen, count unchanged.
  - Full + push, no pop: the new store is dropped, `log_overflow` is set, and the store still counts and classifies.
  - Empty + pop: no effect.
  - Empty + push + pop: the push happens; the pop is ignored because `log_valid` was 0.

## Timing
- Reset: state RUN, all counters 0, FIFO empty, `done`/`pass`/`log_valid`/`log_overflow` 0, `fail_code` 00, `log_addr`/`log_data` 0.
- All outputs are registered. A store sampled at edge N is reflected in `done`, `pass`, `fail_code`, `store_count`, and `log_valid` after edge N; the bench reads them at negedge N.
- FIFO head data is valid in the same cycle as `log_valid`. After a pop at edge N, the next entry appears after edge N.
- Reset asserted mid-test or mid-drain clears everything at that edge. Stores in that cycle are discarded.

## Structure
- Package `store_monitor_pkg`: `state_t` enum {RUN, PASS, FAIL}; `fail_code_t` enum {FC_NONE, FC_BAD_VALUE, FC_MISALIGNED, FC_TIMEOUT}; `log_entry_t` struct {addr, data}.
- Sub-module `sync_fifo`, parameterized by width and depth, with the same active-low sync reset. It provides push/pop/full/empty and drop-on-full semantics, with overflow detection done in the parent.
- Parent holds the FSM, counters, and classification.

## Test plan
- Stores (96,7) then (100,25) → `log_valid`=1 after the first store; `done`=1, `pass`=1, `fail_code`=00, `store_count`=2 after the second; log drains (96,7),(100,25).
- Store (100,24) → `done`=1, `pass`=0, `fail_code`=01; a later store (100,25) is ignored and `store_count` stays 1.
- Store (98,5) → FAIL, code 10, even when the address is `TOHOST_ADDR`+2. Separately, store (TOHOST_ADDR=102 override, 25) → code 10, with misalignment beating pass.
- `TIMEOUT_CYCLES`=10, no stores → `done` after the 10th RUN edge, code 11, `cycle_count`=9 frozen. Store (100,25) on that same cycle → PASS.
- 6 stores to addresses 0,4,…,20 with `log_ready`=0, `LOG_DEPTH`=4 → entries 0..12 kept, `log_overflow`=1, `store_count`=6. Simultaneous push+pop while full keeps 4 entries.
- Drop `reset` to 0 while in PASS with 3 log entries → all outputs return to reset values next cycle, then RUN resumes counting from 0.
